datapath_sequencer: RTL and testbench
=====================================

# datapath_sequencer

Micro-sequencer sitting directly upstream of the register-file/ALU datapath. It executes a small program held in an internal program RAM and drives the datapath control inputs (Wen, WA, RAA, RAB, Op, Sel, Ctrl) one instruction at a time. It branches on the datapath `Flag` output. A start/busy/done handshake exposes it to the testbench or host.

## Interface
- `PROG_DEPTH`, 16: program RAM words; power of two, PC width `PC_W = $clog2(PROG_DEPTH)`.
- `MAX_STEPS`, 255: watchdog, maximum executed instructions per run.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `prog_we`  in  1  program write strobe; honoured only in IDLE.
- `prog_addr`  in  PC_W  program write address.
- `prog_data`  in  20  instruction word.
- `start`  in  1  one-cycle pulse, starts execution at address 0; honoured only in IDLE.
- `busy`  out  1  high from the cycle after an accepted start until DONE/ERROR is entered.
- `done`  out  1  one-cycle pulse on HALT.
- `error`  out  1  sticky; set on illegal class or watchdog, cleared by next accepted start or reset.
- `Flag`  in  1  datapath comparison flag.
- `Wen`  out  1  register write enable.
- `WA`  out  4  write address.
- `RAA`  out  4  read address A.
- `RAB`  out  4  read address B.
- `Op`  out  3  ALU op: 000 ADD, 001 SHR, 010 EQ, 011 AND, 100 MOV.
- `Sel`  out  4  InPort nibble/source select.
- `Ctrl`  out  8  auxiliary control byte.

## Operation
- Instruction class is `[19:17]`.
  - 000 ALU: Op=[16:14], WA=[13:10], RAA=[9:6], RAB=[5:2], Wen=[1].
  - 001 LOAD: Sel=[16:13], WA=[12:9], Ctrl=[7:0], Wen=1.
  - 010 BRF: if Flag=1 then PC<=[PC_W-1:0], else PC+1.
  - 011 JMP: PC<=[PC_W-1:0].
  - 100 HALT.
  - 101..111 illegal.
- States:
  - IDLE: start -> FETCH, PC=0, step count=0, error cleared.
  - FETCH: instr <= mem[PC]; control registers loaded from the instruction -> EXEC.
  - EXEC: controls valid this cycle only. PC updated. Step count +1. -> FETCH, DONE, or ERROR.
  - DONE: done=1 for one cycle -> IDLE.
  - ERROR: error set -> IDLE.
- HALT or illegal class: go to DONE or ERROR respectively. No controls are asserted for that instruction.
- Watchdog: if step count reaches MAX_STEPS at the end of EXEC, go to ERROR instead of FETCH.
- PC increments modulo PROG_DEPTH; wrap from last address to 0 is legal.
- Idle control values (all states except EXEC): Wen=0, WA=RAA=RAB=0, Op=100, Sel=0, Ctrl=0. As a result, Wen is never high outside EXEC.
- prog_we and start in the same IDLE cycle: the write completes, execution starts, and the written word is visible if it is at address 0.
- prog_we while not in IDLE is ignored. start while not in IDLE is ignored.

## Timing
- Every instruction takes 2 cycles (FETCH, EXEC). A taken branch has no extra penalty.
- Control outputs are registered and asserted for exactly one cycle per ALU/LOAD instruction.
- Flag is sampled on the clock edge ending the BRF EXEC cycle. An EQ in EXEC at cycle n updates Flag by edge n+1, so BRF immediately after EQ (EXEC at n+2) sees the new value.
- start accepted at edge t: busy=1 from t+1, first EXEC at cycle t+2.
- done rises the cycle after the HALT FETCH. busy drops in the same cycle.
- Reset: state=IDLE, PC=0, busy=0, done=0, error=0, controls at idle values. Program RAM contents are not reset.
- Reset mid-run aborts immediately. No done pulse is produced; the next cycle is IDLE.

## Structure
- `datapath_sequencer_pkg`: class enum, Op encodings, state enum, field bit positions, idle control constants.
- Sub-module `seq_prog_mem`: PROG_DEPTH x 20 RAM with synchronous write and synchronous read.
- Top level: FSM, PC, step counter, output registers.

## Test plan
- Program {ALU ADD WA=3 RAA=1 RAB=2 wen=1; HALT}, start -> Wen=1, WA=3, Op=000 for exactly one cycle at t+2; done pulse at t+4; busy low afterwards.
- Program {ALU EQ RAA=1 RAB=1; BRF ->5; HALT; ...; addr5 LOAD Sel=7 WA=4 Ctrl=0xA5; HALT} with Flag driven 1 after EQ -> LOAD controls appear, done asserted. Repeat with Flag=0 -> done with no LOAD.
- Word with class 110 at address 0 -> error=1, busy low after 2 cycles, no Wen. A following start clears error.
- Program JMP->0 at address 0 with MAX_STEPS=255 -> error after 255 EXEC cycles. PC-wrap variant: program fills all 16 words with NOP-ALU (wen=0) -> PC wraps to 0, watchdog fires.
- rst asserted during EXEC of an ALU write -> next cycle Wen=0, busy=0, done=0. start pressed while busy is ignored, and prog_we while busy leaves the RAM unchanged.

Source files
------------

// File: rtl/datapath_sequencer_pkg.sv
// Shared definitions for the datapath micro-sequencer.
// Contents: instruction class enum, ALU op encodings, FSM state enum,
// instruction field positions, the control bundle with its idle value,
// and the instruction decoder.
package datapath_sequencer_pkg;

    localparam int INSTR_W = 20;

    // Field positions
    localparam int CLS_LSB     = 17;   // [19:17]
    localparam int ALU_OP_LSB  = 14;   // [16:14]
    localparam int ALU_WA_LSB  = 10;   // [13:10]
    localparam int ALU_RAA_LSB = 6;    // [9:6]
    localparam int ALU_RAB_LSB = 2;    // [5:2]
    localparam int ALU_WEN_BIT = 1;
    localparam int LD_SEL_LSB  = 13;   // [16:13]
    localparam int LD_WA_LSB   = 9;    // [12:9]
    localparam int LD_CTRL_LSB = 0;    // [7:0]

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SHR = 3'b001;
    localparam logic [2:0] OP_EQ  = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_MOV = 3'b100;

    // Codes 101..111 are illegal and fall to the default arm of any decode.
    typedef enum logic [2:0] {
        CLS_ALU  = 3'b000,
        CLS_LOAD = 3'b001,
        CLS_BRF  = 3'b010,
        CLS_JMP  = 3'b011,
        CLS_HALT = 3'b100
    } cls_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_DONE,
        S_ERROR
    } state_e;

    typedef struct packed {
        logic       wen;
        logic [3:0] wa;
        logic [3:0] raa;
        logic [3:0] rab;
        logic [2:0] op;
        logic [3:0] sel;
        logic [7:0] ctrl;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{wen: 1'b0, wa: 4'd0, raa: 4'd0, rab: 4'd0,
                                    op: OP_MOV, sel: 4'd0, ctrl: 8'd0};

    // Datapath controls for one instruction; anything that is not ALU or
    // LOAD leaves the datapath at its idle values.
    function automatic ctrl_t decode_ctrl(input logic [INSTR_W-1:0] instr);
        ctrl_t c;
        c = CTRL_IDLE;
        case (cls_e'(instr[CLS_LSB +: 3]))
            CLS_ALU: begin
                c.op  = instr[ALU_OP_LSB +: 3];
                c.wa  = instr[ALU_WA_LSB +: 4];
                c.raa = instr[ALU_RAA_LSB +: 4];
                c.rab = instr[ALU_RAB_LSB +: 4];
                c.wen = instr[ALU_WEN_BIT];
            end
            CLS_LOAD: begin
                c.sel  = instr[LD_SEL_LSB +: 4];
                c.wa   = instr[LD_WA_LSB +: 4];
                c.ctrl = instr[LD_CTRL_LSB +: 8];
                c.wen  = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/datapath_sequencer_prog_mem.sv
// seq_prog_mem: program RAM, DEPTH x DW, synchronous write and synchronous read.
// A read of the address being written in the same cycle returns the new word.
// Ports:
//   clk      clock
//   we_i     write strobe
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address, sampled on the rising edge
//   rdata_o  registered read data
module seq_prog_mem #(
    parameter int DEPTH = 16,
    parameter int DW    = 20,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // NOTE: the array and read register have no reset, so they stay plain RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/datapath_sequencer.sv
// datapath_sequencer: runs a program from internal RAM, driving the
// register-file/ALU control inputs one instruction at a time (FETCH, EXEC).
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   prog_we, prog_addr, prog_data    program load port (IDLE only)
//   start / busy / done / error      host handshake
//   Flag                             datapath compare flag, used by BRF
//   Wen, WA, RAA, RAB, Op, Sel, Ctrl registered datapath controls
module datapath_sequencer
    import datapath_sequencer_pkg::*;
#(
    parameter int PROG_DEPTH = 16,
    parameter int MAX_STEPS  = 255,
    localparam int PC_W      = $clog2(PROG_DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               prog_we,
    input  logic [PC_W-1:0]    prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               error,
    input  logic               Flag,
    output logic               Wen,
    output logic [3:0]         WA,
    output logic [3:0]         RAA,
    output logic [3:0]         RAB,
    output logic [2:0]         Op,
    output logic [3:0]         Sel,
    output logic [7:0]         Ctrl
);

    localparam int STEP_W = $clog2(MAX_STEPS + 1);

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d, pc_inc;
    logic [STEP_W-1:0]  step_q, step_d;
    logic               err_q, err_d;
    ctrl_t              ctrl_q, ctrl_d;
    cls_e               cls_q, cls_d, fetch_cls;
    logic [PC_W-1:0]    tgt_q, tgt_d;
    logic [INSTR_W-1:0] rdata;
    logic               mem_we;

    assign mem_we = prog_we && (state_q == S_IDLE);

    // Read address is the next PC so the word is already in rdata during FETCH.
    seq_prog_mem #(
        .DEPTH (PROG_DEPTH),
        .DW    (INSTR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (prog_addr),
        .wdata_i (prog_data),
        .raddr_i (pc_d),
        .rdata_o (rdata)
    );

    assign fetch_cls = cls_e'(rdata[CLS_LSB +: 3]);
    assign pc_inc    = pc_q + 1'b1;   // natural wrap at PROG_DEPTH

    // NOTE: every always_comb output gets a default first, so no latches.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        step_d  = step_q;
        err_d   = err_q;
        ctrl_d  = CTRL_IDLE;
        cls_d   = cls_q;
        tgt_d   = tgt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    step_d  = '0;
                    err_d   = 1'b0;
                end
            end
            S_FETCH: begin
                cls_d = fetch_cls;
                tgt_d = rdata[PC_W-1:0];
                case (fetch_cls)
                    CLS_ALU, CLS_LOAD, CLS_BRF, CLS_JMP: begin
                        state_d = S_EXEC;
                        ctrl_d  = decode_ctrl(rdata);
                    end
                    CLS_HALT: state_d = S_DONE;
                    default: begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                    end
                endcase
            end
            S_EXEC: begin
                step_d = step_q + 1'b1;
                case (cls_q)
                    CLS_BRF: pc_d = Flag ? tgt_q : pc_inc;
                    CLS_JMP: pc_d = tgt_q;
                    default: pc_d = pc_inc;
                endcase
                if (step_d == STEP_W'(MAX_STEPS)) begin
                    state_d = S_ERROR;
                    err_d   = 1'b1;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DONE, S_ERROR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            step_q  <= '0;
            err_q   <= 1'b0;
            ctrl_q  <= CTRL_IDLE;
            cls_q   <= CLS_ALU;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            step_q  <= step_d;
            err_q   <= err_d;
            ctrl_q  <= ctrl_d;
            cls_q   <= cls_d;
            tgt_q   <= tgt_d;
        end
    end

    assign busy  = (state_q == S_FETCH) || (state_q == S_EXEC);
    assign done  = (state_q == S_DONE);
    assign error = err_q;

    assign Wen  = ctrl_q.wen;
    assign WA   = ctrl_q.wa;
    assign RAA  = ctrl_q.raa;
    assign RAB  = ctrl_q.rab;
    assign Op   = ctrl_q.op;
    assign Sel  = ctrl_q.sel;
    assign Ctrl = ctrl_q.ctrl;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed testbench for datapath_sequencer.
module tb_datapath_sequencer;
    import datapath_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [19:0] prog_data = '0;
    logic        start = 1'b0;
    logic        busy, done, error;
    logic        Flag = 1'b0;
    logic        Wen;
    logic [3:0]  WA, RAA, RAB, Sel;
    logic [2:0]  Op;
    logic [7:0]  Ctrl;

    datapath_sequencer #(.PROG_DEPTH(16), .MAX_STEPS(255)) dut (
        .clk       (clk),
        .rst       (rst),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .Flag      (Flag),
        .Wen       (Wen),
        .WA        (WA),
        .RAA       (RAA),
        .RAB       (RAB),
        .Op        (Op),
        .Sel       (Sel),
        .Ctrl      (Ctrl)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [19:0] enc_alu(input logic [2:0] op, input logic [3:0] wa,
                                            input logic [3:0] raa, input logic [3:0] rab,
                                            input logic wen);
        return {3'b000, op, wa, raa, rab, wen, 1'b0};
    endfunction

    function automatic logic [19:0] enc_load(input logic [3:0] sel, input logic [3:0] wa,
                                             input logic [7:0] c);
        return {3'b001, sel, wa, 1'b0, c};
    endfunction

    function automatic logic [19:0] enc_br(input logic [2:0] cls, input logic [3:0] tgt);
        return {cls, 13'd0, tgt};
    endfunction

    localparam logic [19:0] W_HALT = {3'b100, 17'd0};
    localparam logic [19:0] W_ILL  = {3'b110, 17'd0};

    task automatic write_word(input logic [3:0] a, input logic [19:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we   = 1'b0;
    endtask

    // Results of the last run; k counts cycles after the start edge (k=1 is t+1).
    int         r_end_k, r_nwen, r_wen_k, r_nand;
    logic       r_end_err, r_busy_end, r_err1;
    logic [3:0] r_wa, r_raa, r_rab, r_sel;
    logic [7:0] r_ctrl;
    logic [2:0] r_op;

    // Starts a run and watches it until done/error. eq_flag models the datapath
    // Flag produced by an EQ; poke presses start and prog_we during k=1..2;
    // sw writes sw_data to address 0 in the start cycle itself.
    task automatic run(input int limit, input logic eq_flag, input logic poke,
                       input logic sw, input logic [19:0] sw_data);
        int k;
        r_end_k = -1; r_nwen = 0; r_wen_k = -1; r_nand = 0;
        r_end_err = 1'b0; r_busy_end = 1'b1; r_err1 = 1'b1;
        Flag = 1'b0;
        start = 1'b1; prog_we = sw; prog_addr = 4'd0; prog_data = sw_data;
        tick();
        start = 1'b0; prog_we = 1'b0;
        k = 1;
        while (k <= limit && r_end_k < 0) begin
            if (k == 1) r_err1 = error;
            if (Wen) begin
                r_nwen++;
                if (r_wen_k < 0) r_wen_k = k;
                r_wa = WA; r_raa = RAA; r_rab = RAB; r_op = Op; r_sel = Sel; r_ctrl = Ctrl;
            end
            if (Op == OP_AND) r_nand++;
            if (Op == OP_EQ) Flag = eq_flag;
            if (done || error) begin
                r_end_k = k; r_end_err = error; r_busy_end = busy;
            end else begin
                if (poke && k <= 2) begin
                    start = 1'b1; prog_we = 1'b1; prog_addr = 4'd1;
                    prog_data = enc_alu(OP_ADD, 4'd9, 4'd0, 4'd0, 1'b1);
                end else begin
                    start = 1'b0; prog_we = 1'b0;
                end
                tick();
                k++;
            end
        end
        start = 1'b0; prog_we = 1'b0;
        if (r_end_k < 0) check("run_end_seen", {31'd0, done | error}, 32'd1);
        tick();   // back to IDLE
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        tick(); tick();
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_wen", Wen, 0);
        check("rst_op", Op, 3'b100);
        check("rst_wa_sel_ctrl", {WA, Sel, Ctrl}, 0);

        // ALU ADD then HALT
        write_word(4'd0, enc_alu(OP_ADD, 4'd3, 4'd1, 4'd2, 1'b1));
        write_word(4'd1, W_HALT);
        run(20, 1'b0, 1'b0, 1'b0, '0);
        check("add_done_k", r_end_k, 4);
        check("add_err", r_end_err, 0);
        check("add_nwen", r_nwen, 1);
        check("add_wen_k", r_wen_k, 2);
        check("add_fields", {r_wa, r_raa, r_rab, 1'b0, r_op}, {4'd3, 4'd1, 4'd2, 1'b0, 3'b000});
        check("add_busy_end", r_busy_end, 0);
        check("add_done_after", done, 0);

        // EQ; BRF ->5; HALT; ... 5: LOAD; HALT
        write_word(4'd0, enc_alu(OP_EQ, 4'd0, 4'd1, 4'd1, 1'b0));
        write_word(4'd1, enc_br(3'b010, 4'd5));
        write_word(4'd2, W_HALT);
        write_word(4'd5, enc_load(4'd7, 4'd4, 8'hA5));
        write_word(4'd6, W_HALT);
        run(30, 1'b1, 1'b0, 1'b0, '0);
        check("brt_done_k", r_end_k, 8);
        check("brt_nwen", r_nwen, 1);
        check("brt_wen_k", r_wen_k, 6);
        check("brt_load", {r_sel, r_wa, r_ctrl}, {4'd7, 4'd4, 8'hA5});
        run(30, 1'b0, 1'b0, 1'b0, '0);
        check("brn_done_k", r_end_k, 6);
        check("brn_nwen", r_nwen, 0);
        check("brn_err", r_end_err, 0);

        // write and start in the same cycle: new word at 0 is executed
        run(20, 1'b0, 1'b0, 1'b1, W_HALT);
        check("sw_done_k", r_end_k, 2);
        check("sw_err", r_end_err, 0);

        // illegal class
        write_word(4'd0, W_ILL);
        run(20, 1'b0, 1'b0, 1'b0, '0);
        check("ill_k", r_end_k, 2);
        check("ill_err", r_end_err, 1);
        check("ill_busy", r_busy_end, 0);
        check("ill_nwen", r_nwen, 0);
        check("ill_sticky", error, 1);
        run(20, 1'b0, 1'b0, 1'b0, '0);
        check("ill_clear_on_start", r_err1, 0);
        check("ill_again", r_end_err, 1);

        // reset during EXEC of an ALU write
        write_word(4'd0, enc_alu(OP_ADD, 4'd3, 4'd1, 4'd2, 1'b1));
        write_word(4'd1, W_HALT);
        start = 1'b1; tick(); start = 1'b0;
        tick();
        check("rstx_wen_before", Wen, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("rstx_wen", Wen, 0);
        check("rstx_busy", busy, 0);
        check("rstx_done", done, 0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (done || busy) cnt++;
            tick();
        end
        check("rstx_quiet", cnt, 0);

        // start and prog_we while busy are ignored
        run(20, 1'b0, 1'b1, 1'b0, '0);
        check("poke_done_k", r_end_k, 4);
        check("poke_nwen", r_nwen, 1);
        run(20, 1'b0, 1'b0, 1'b0, '0);
        check("poke_ram_kept", r_nwen, 1);
        check("poke_wa", r_wa, 3);

        // watchdog on JMP 0
        write_word(4'd0, enc_br(3'b011, 4'd0));
        run(600, 1'b0, 1'b0, 1'b0, '0);
        check("wd_jmp_k", r_end_k, 511);
        check("wd_jmp_err", r_end_err, 1);
        check("wd_jmp_nwen", r_nwen, 0);

        // watchdog with PC wrap over 16 NOP ALUs; word 0 is marked with AND
        write_word(4'd0, enc_alu(OP_AND, 4'd0, 4'd1, 4'd1, 1'b0));
        for (int a = 1; a < 16; a++) write_word(4'(a), enc_alu(OP_ADD, 4'd0, 4'd0, 4'd0, 1'b0));
        run(600, 1'b0, 1'b0, 1'b0, '0);
        check("wd_wrap_k", r_end_k, 511);
        check("wd_wrap_err", r_end_err, 1);
        check("wd_wrap_addr0_hits", r_nand, 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
